syn_wm8731_cfg_seq: RTL

//  Sequences a table of WM8731 register writes through the I2C master's local-bus register

---
 rtl/syn_wm8731_cfg_seq_if.sv | 21 ++
 rtl/syn_wm8731_cfg_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/syn_wm8731_cfg_seq_if.sv
// Local-bus port of the I2C master register file: one strobe outstanding at a time,
// completion signalled by the matching valid.
interface syn_wm8731_cfg_seq_if;
   logic        i2cm_wr_en;
   logic        i2cm_rd_en;
   logic [7:0]  i2cm_addr;
   logic [15:0] i2cm_wr_data;
   logic        i2cm_wr_valid;
   logic        i2cm_rd_valid;
   logic [15:0] i2cm_rd_data;

   modport master (
      output i2cm_wr_en, i2cm_rd_en, i2cm_addr, i2cm_wr_data,
      input  i2cm_wr_valid, i2cm_rd_valid, i2cm_rd_data
   );

   modport slave (
      input  i2cm_wr_en, i2cm_rd_en, i2cm_addr, i2cm_wr_data,
      output i2cm_wr_valid, i2cm_rd_valid, i2cm_rd_data
   );
endinterface

// File: rtl/syn_wm8731_cfg_seq.sv
// WM8731 configuration sequencer: walks a register table and writes each entry through
// the I2C master, polling status with NACK retry and poll timeout.
module syn_wm8731_cfg_seq #(
   parameter int         P_NUM_ENTRIES = 8,
   parameter logic [7:0] P_DEV_ADDR    = 8'h34,
   parameter logic [7:0] P_CLK_DIV     = 8'hFF,
   parameter int         P_MAX_RETRY   = 3,
   parameter int         P_POLL_GAP    = 16,
   parameter int         P_POLL_MAX    = 255,
   parameter logic [7:0] P_REG_STATUS  = 8'h0,
   parameter logic [7:0] P_REG_ADDR    = 8'h1,
   parameter logic [7:0] P_REG_DATA    = 8'h2,
   parameter logic [7:0] P_REG_CLKDIV  = 8'h3
) (
   input  logic        clk_ir,
   input  logic        rst_sync_l,
   input  logic        cfg_start,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic [1:0]  cfg_err,
   output logic [5:0]  cfg_err_idx,
   output logic [5:0]  tbl_rd_idx,
   input  logic [15:0] tbl_rd_data,
   syn_wm8731_cfg_seq_if.master lb
);
   localparam int RW = (P_MAX_RETRY < 4) ? 2 : $clog2(P_MAX_RETRY + 1);
   localparam int GW = (P_POLL_GAP < 2) ? 1 : $clog2(P_POLL_GAP);
   localparam logic [RW-1:0] RETRY_LAST = RW'(P_MAX_RETRY);
   localparam logic [GW-1:0] GAP_LAST   = GW'(P_POLL_GAP - 1);
   localparam logic [7:0]    POLL_LAST  = 8'(P_POLL_MAX);
   localparam logic [5:0]    IDX_LAST   = 6'(P_NUM_ENTRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CLKDIV, S_CLKDIV_W, S_DEVADR, S_DEVADR_W, S_FETCH, S_CAPT, S_DATA,
      S_DATA_W, S_START, S_START_W, S_GAP, S_POLL, S_POLL_W, S_NEXT, S_END
   } state_t;

   state_t          state, state_nxt;
   logic [5:0]      idx, idx_nxt;
   logic [RW-1:0]   retry, retry_nxt;
   logic [7:0]      poll, poll_nxt;
   logic [GW-1:0]   gap, gap_nxt;
   logic [15:0]     word, word_nxt;
   logic [1:0]      err, err_nxt;
   logic [5:0]      err_idx, err_idx_nxt;
   logic            wr_en, rd_en;
   logic [7:0]      addr;
   logic [15:0]     wr_data;
   logic            st_busy, st_nack;
   logic            unused_rd;

   assign st_busy   = lb.i2cm_rd_data[0];
   assign st_nack   = lb.i2cm_rd_data[1];
   assign unused_rd = &{1'b0, lb.i2cm_rd_data[15:2]};

   always_ff @(posedge clk_ir or negedge rst_sync_l) begin
      if (!rst_sync_l) begin
         state   <= S_IDLE;
         idx     <= '0;
         retry   <= '0;
         poll    <= '0;
         gap     <= '0;
         word    <= '0;
         err     <= '0;
         err_idx <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         retry   <= retry_nxt;
         poll    <= poll_nxt;
         gap     <= gap_nxt;
         word    <= word_nxt;
         err     <= err_nxt;
         err_idx <= err_idx_nxt;
      end
   end

   // Strobes pulse in the issue state; addr/data are held through the *_W wait state.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      retry_nxt   = retry;
      poll_nxt    = poll;
      gap_nxt     = gap;
      word_nxt    = word;
      err_nxt     = err;
      err_idx_nxt = err_idx;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      addr        = 8'h0;
      wr_data     = 16'h0;
      case (state)
         S_IDLE: if (cfg_start) begin
            state_nxt   = S_CLKDIV;
            err_nxt     = 2'b00;
            err_idx_nxt = '0;
            idx_nxt     = '0;
            retry_nxt   = '0;
         end
         S_CLKDIV, S_CLKDIV_W: begin
            addr    = P_REG_CLKDIV;
            wr_data = {8'h0, P_CLK_DIV};
            wr_en   = (state == S_CLKDIV);
            if (state == S_CLKDIV) state_nxt = S_CLKDIV_W;
            else if (lb.i2cm_wr_valid) state_nxt = S_DEVADR;
         end
         S_DEVADR, S_DEVADR_W: begin
            addr    = P_REG_ADDR;
            wr_data = {8'h0, P_DEV_ADDR};
            wr_en   = (state == S_DEVADR);
            if (state == S_DEVADR) state_nxt = S_DEVADR_W;
            else if (lb.i2cm_wr_valid) state_nxt = S_FETCH;
         end
         S_FETCH: state_nxt = S_CAPT;
         S_CAPT: begin
            word_nxt  = tbl_rd_data;
            state_nxt = S_DATA;
         end
         S_DATA, S_DATA_W: begin
            addr    = P_REG_DATA;
            wr_data = word;
            wr_en   = (state == S_DATA);
            if (state == S_DATA) state_nxt = S_DATA_W;
            else if (lb.i2cm_wr_valid) state_nxt = S_START;
         end
         S_START, S_START_W: begin
            addr  = P_REG_STATUS;
            wr_en = (state == S_START);
            if (state == S_START) begin
               poll_nxt  = '0;
               state_nxt = S_START_W;
            end else if (lb.i2cm_wr_valid) begin
               gap_nxt   = '0;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (gap == GAP_LAST) state_nxt = S_POLL;
            else gap_nxt = gap + 1'b1;
         end
         S_POLL: begin
            addr      = P_REG_STATUS;
            rd_en     = 1'b1;
            poll_nxt  = (poll == 8'hFF) ? poll : poll + 8'd1;
            state_nxt = S_POLL_W;
         end
         S_POLL_W: begin
            addr = P_REG_STATUS;
            if (lb.i2cm_rd_valid) begin
               if (st_busy) begin
                  if (poll >= POLL_LAST) begin
                     err_nxt     = 2'b10;
                     err_idx_nxt = idx;
                     state_nxt   = S_END;
                  end else begin
                     gap_nxt   = '0;
                     state_nxt = S_GAP;
                  end
               end else if (st_nack) begin
                  if (retry < RETRY_LAST) begin
                     retry_nxt = retry + 1'b1;
                     state_nxt = S_DATA;
                  end else begin
                     err_nxt     = 2'b01;
                     err_idx_nxt = idx;
                     state_nxt   = S_END;
                  end
               end else begin
                  state_nxt = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            if (idx >= IDX_LAST) state_nxt = S_END;
            else begin
               idx_nxt   = idx + 6'd1;
               retry_nxt = '0;
               state_nxt = S_FETCH;
            end
         end
         S_END:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cfg_busy        = (state != S_IDLE);
   assign cfg_done        = (state == S_END);
   assign cfg_err         = err;
   assign cfg_err_idx     = err_idx;
   assign tbl_rd_idx      = idx;
   assign lb.i2cm_wr_en   = wr_en;
   assign lb.i2cm_rd_en   = rd_en;
   assign lb.i2cm_addr    = addr;
   assign lb.i2cm_wr_data = wr_data;
endmodule
